muldiv_scheduler: RTL and testbench

Iterative multiply/divide sequencer for the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the Execute stage and runs a shift-add multiply or restoring divide over WIDTH cycles. It owns the HI/LO registers. It raises a stall request that the hazard unit ORs into StallF/StallD/FlushE while a Decode-stage HI/LO reader or a new mul/div instruction would collide with an operation in flight.

---
 rtl/muldiv_scheduler.sv | 160 ++++++++++++++++
 tb/tb_muldiv_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_scheduler.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: shift-add multiply or restoring divide
// over WIDTH cycles, one sign-fix cycle, and a stall request for the hazard unit.
module muldiv_scheduler #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             MfhiD,
  input  logic             MfloD,
  input  logic             MulDivD,
  output logic             StallMD,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    a_neg = ~OpE[0] & SrcAE[WIDTH-1];
    b_neg = ~OpE[0] & SrcBE[WIDTH-1];
    a_mag = a_neg ? -SrcAE : SrcAE;
    b_mag = b_neg ? -SrcBE : SrcBE;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}; the carry re-enters on shift.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Divide: acc = {rem, quot}. rem_sh can exceed WIDTH bits, so compare at WIDTH+1 bits; with a
  // zero divisor every trial succeeds and rem simply collects the dividend bits.
  always_comb begin
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, opnd_q};
    if (rem_sh >= {1'b0, opnd_q}) begin
      div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (StartE) begin
          state_d   = StRun;
          cnt_d     = CntW'(WIDTH - 1);
          is_div_d  = OpE[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (OpE[1]) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign Busy    = (state_q != StIdle);
  assign Done    = done_q;
  assign HiOut   = hi_q;
  assign LoOut   = lo_q;
  assign StallMD = (MfhiD | MfloD | MulDivD) & (Busy | StartE);

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Bench for muldiv_scheduler: arithmetic reference model with a per-cycle compare process,
// plus directed operations with hand-computed HI/LO literals.
module tb_muldiv_scheduler;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         StartE = 1'b0;
  logic [1:0]   OpE = 2'b00;
  logic [W-1:0] SrcAE = '0;
  logic [W-1:0] SrcBE = '0;
  logic         MfhiD = 1'b0;
  logic         MfloD = 1'b0;
  logic         MulDivD = 1'b0;
  logic         StallMD, Busy, Done;
  logic [W-1:0] HiOut, LoOut;

  muldiv_scheduler #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .StartE (StartE),
    .OpE    (OpE),
    .SrcAE  (SrcAE),
    .SrcBE  (SrcBE),
    .MfhiD  (MfhiD),
    .MfloD  (MfloD),
    .MulDivD(MulDivD),
    .StallMD(StallMD),
    .Busy   (Busy),
    .Done   (Done),
    .HiOut  (HiOut),
    .LoOut  (LoOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Reference results straight from integer arithmetic.
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint     sp;
    logic [63:0] up;
    int         q, r;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = sp;
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      2'd2: begin
        if (b == 0) begin
          hi = a;
          lo = a[W-1] ? 32'd1 : 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0;
          lo = 32'h8000_0000;
        end else begin
          q  = $signed(a) / $signed(b);
          r  = $signed(a) % $signed(b);
          hi = r;
          lo = q;
        end
      end
      default: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endfunction

  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  // Model: result lands WIDTH+1 edges after the accepted start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        check("start_while_busy", W'(StartE), '0);
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1'b1;
        end
      end else if (StartE) begin
        ref_op(OpE, SrcAE, SrcBE, p_hi, p_lo);
        m_cnt = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_busy", W'(Busy), W'(m_cnt > 0));
      check("cyc_done", W'(Done), W'(m_done));
      check("cyc_hi", HiOut, m_hi);
      check("cyc_lo", LoOut, m_lo);
      check("cyc_stall", W'(StallMD), W'((MfhiD | MfloD | MulDivD) & ((m_cnt > 0) | StartE)));
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    OpE    = op;
    SrcAE  = a;
    SrcBE  = b;
    StartE = 1'b1;
    @(posedge clk);
    #1;
    StartE = 1'b0;
  endtask

  // Returns 1 ns after the negedge of the Done cycle.
  task automatic wait_done(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo,
                           output int busy_n);
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    for (int n = 0; n < int'(W) + 8 && !seen; n++) begin
      @(negedge clk);
      if (Busy) busy_n++;
      if (Done) seen = 1'b1;
    end
    check({name, "_done_seen"}, W'(seen), W'(1));
    if (seen) begin
      check({name, "_hi"}, HiOut, hi);
      check({name, "_lo"}, LoOut, lo);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bn;
    int stalls;
    bit seen;
    #12 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", W'(Busy), '0);
    check("reset_done", W'(Done), '0);
    check("reset_hi", HiOut, '0);
    check("reset_lo", LoOut, '0);
    #1;

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, bn);
    check("multu_busy_cycles", bn, 33);
    @(negedge clk);
    check("multu_done_once", W'(Done), '0);
    #1;

    issue(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, bn);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFD, bn);
    check("div_b2b_busy_cycles", bn, 33);

    issue(2'd3, 32'd7, 32'd0);
    wait_done("divu_zero", 32'd7, 32'hFFFF_FFFF, bn);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32'd0, 32'h8000_0000, bn);
    issue(2'd2, 32'hFFFF_FFF9, 32'd0);
    wait_done("div_neg_zero", 32'hFFFF_FFF9, 32'd1, bn);
    issue(2'd2, 32'hFFFF_FF9C, 32'd7);
    wait_done("div_neg_rem", 32'hFFFF_FFFE, 32'hFFFF_FFF2, bn);

    // MFLO following MULTU stays stalled until the Done cycle.
    issue(2'd1, 32'd6, 32'd7);
    MfloD  = 1'b1;
    stalls = 0;
    seen   = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (Done) begin
        seen = 1'b1;
      end else begin
        check("mflo_stall", W'(StallMD), W'(1));
        stalls++;
      end
    end
    check("mflo_done_seen", W'(seen), W'(1));
    check("mflo_stall_cycles", stalls, 33);
    check("mflo_release", W'(StallMD), '0);
    check("mflo_lo", LoOut, 32'd42);
    #1;
    MfloD = 1'b0;

    // Stall through the StartE term, then through Busy.
    OpE     = 2'd0;
    SrcAE   = 32'hFFFF_FFFF;
    SrcBE   = 32'h8000_0000;
    StartE  = 1'b1;
    MulDivD = 1'b1;
    #1;
    check("stall_start_term", W'(StallMD), W'(1));
    @(posedge clk);
    #1;
    StartE = 1'b0;
    @(negedge clk);
    check("stall_muldiv_busy", W'(StallMD), W'(1));
    #1;
    MulDivD = 1'b0;
    wait_done("mult_min", 32'd0, 32'h8000_0000, bn);
    MfhiD = 1'b1;
    #1;
    check("stall_idle_mfhi", W'(StallMD), '0);
    #1;
    MfhiD = 1'b0;

    // Reset mid-RUN aborts and clears HI/LO.
    issue(2'd3, 32'd100, 32'd3);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_busy", W'(Busy), '0);
    check("rst_done", W'(Done), '0);
    check("rst_hi", HiOut, '0);
    check("rst_lo", LoOut, '0);
    @(negedge clk);
    #1 rst = 1'b0;
    issue(2'd3, 32'd100, 32'd3);
    wait_done("divu_after_rst", 32'd1, 32'd33, bn);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
